// File: rtl/i2c_access_arbiter.sv
// Round-robin arbiter sharing one I2C master between diagnostics clients.
// One byte transaction per grant, with a start-to-done watchdog on the master.
module i2c_access_arbiter #(
  parameter int g_requesters = 4,
  parameter int g_timeout    = 2_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [g_requesters-1:0]     Req_ib,
  input  logic [g_requesters*7-1:0]   Addr_ib,
  input  logic [g_requesters-1:0]     Rnw_ib,
  input  logic [g_requesters*8-1:0]   Wdata_ib,
  output logic [g_requesters-1:0]     Grant_ob,
  output logic [g_requesters-1:0]     Done_ob,
  output logic [7:0]                  Rdata_ob8,
  output logic                        Err_o,
  output logic                        MStart_o,
  output logic [6:0]                  MAddr_ob7,
  output logic                        MRnw_o,
  output logic [7:0]                  MWdata_ob8,
  output logic                        MAbort_o,
  input  logic                        MBusy_i,
  input  logic                        MDone_i,
  input  logic                        MNack_i,
  input  logic [7:0]                  MRdata_ib8
);
  localparam int IW = (g_requesters > 1) ? $clog2(g_requesters) : 1;
  localparam int TW = $clog2(g_timeout);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           rr_q, rr_d;
  logic [IW-1:0]           gidx_q, gidx_d;
  logic [g_requesters-1:0] grant_q, grant_d;
  logic [6:0]              maddr_q, maddr_d;
  logic                    mrnw_q, mrnw_d;
  logic [7:0]              mwdata_q, mwdata_d;
  logic [7:0]              rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    mstart_q, mstart_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    abort;
  logic                    win_found;
  int                      win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    // Scan starting at the round-robin pointer so the last winner goes to the back.
    for (int k = 0; k < g_requesters; k++) begin
      if (!win_found && Req_ib[(int'(rr_q) + k) % g_requesters]) begin
        win_found = 1'b1;
        win_idx   = (int'(rr_q) + k) % g_requesters;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    maddr_d  = maddr_q;
    mrnw_d   = mrnw_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mstart_d = 1'b0;
    timer_d  = timer_q;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: if (|Req_ib) state_d = S_ARB;
      S_ARB: begin
        if (!win_found) begin
          state_d = S_IDLE;
        end else if (!MBusy_i) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = IW'(win_idx);
          maddr_d          = Addr_ib[win_idx*7 +: 7];
          mrnw_d           = Rnw_ib[win_idx];
          mwdata_d         = Wdata_ib[win_idx*8 +: 8];
          state_d          = S_START;
        end
      end
      S_START: begin
        mstart_d = 1'b1;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final timer cycle takes priority over the abort.
        if (MDone_i) begin
          if (mrnw_q) rdata_d = MRdata_ib8;
          err_d   = MNack_i;
          state_d = S_DONE;
        end else if (timer_q == TW'(g_timeout - 1)) begin
          abort   = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        rr_d    = (int'(gidx_q) == g_requesters - 1) ? '0 : gidx_q + IW'(1);
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      maddr_q  <= '0;
      mrnw_q   <= 1'b0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mstart_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      maddr_q  <= maddr_d;
      mrnw_q   <= mrnw_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mstart_q <= mstart_d;
      timer_q  <= timer_d;
    end
  end

  assign Grant_ob   = grant_q;
  assign Done_ob    = (state_q == S_DONE) ? grant_q : '0;
  assign Rdata_ob8  = rdata_q;
  assign Err_o      = err_q;
  assign MStart_o   = mstart_q;
  assign MAddr_ob7  = maddr_q;
  assign MRnw_o     = mrnw_q;
  assign MWdata_ob8 = mwdata_q;
  assign MAbort_o   = abort;
endmodule

// File: tb/tb_i2c_access_arbiter.sv
// Bench for i2c_access_arbiter: directed table, corner sequences and random
// traffic checked against a transaction-level round-robin model.
module tb_i2c_access_arbiter;
  localparam int N = 4;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] Req_ib = '0, Rnw_ib = '0;
  logic [N*7-1:0] Addr_ib = '0;
  logic [N*8-1:0] Wdata_ib = '0;
  logic [N-1:0] Grant_ob, Done_ob;
  logic [7:0] Rdata_ob8, MWdata_ob8, MRdata_ib8 = '0;
  logic [6:0] MAddr_ob7;
  logic Err_o, MStart_o, MRnw_o, MAbort_o;
  logic MBusy_i = 1'b0, MDone_i = 1'b0, MNack_i = 1'b0;

  i2c_access_arbiter #(.g_requesters(N), .g_timeout(TMO)) dut (
    .clk(clk), .rst(rst), .Req_ib(Req_ib), .Addr_ib(Addr_ib), .Rnw_ib(Rnw_ib),
    .Wdata_ib(Wdata_ib), .Grant_ob(Grant_ob), .Done_ob(Done_ob), .Rdata_ob8(Rdata_ob8),
    .Err_o(Err_o), .MStart_o(MStart_o), .MAddr_ob7(MAddr_ob7), .MRnw_o(MRnw_o),
    .MWdata_ob8(MWdata_ob8), .MAbort_o(MAbort_o), .MBusy_i(MBusy_i), .MDone_i(MDone_i),
    .MNack_i(MNack_i), .MRdata_ib8(MRdata_ib8));

  always #5 clk = ~clk;

  int tests = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural I2C master: busy from start until done, optional silence.
  int m_delay = 1, cnt = 0, start_cnt = 0, start_cyc = 0, abort_cyc = 0;
  logic m_nack = 1'b0, m_silent = 1'b0, active = 1'b0;
  logic [7:0] m_rdata = '0;
  always @(negedge clk) begin
    if (rst) begin
      MBusy_i = 1'b0; MDone_i = 1'b0; MNack_i = 1'b0; active = 1'b0;
    end else begin
      if (MDone_i) begin
        MDone_i = 1'b0; MNack_i = 1'b0; MBusy_i = 1'b0; active = 1'b0;
      end
      if (MAbort_o) begin
        abort_cyc = cyc; MBusy_i = 1'b0; active = 1'b0;
      end
      if (MStart_o) begin
        chk("mstart_while_busy", 32'(MBusy_i), 32'd0);
        start_cnt++; start_cyc = cyc;
        MBusy_i = 1'b1; active = 1'b1; cnt = m_delay;
      end else if (active && !m_silent) begin
        cnt--;
        if (cnt <= 0) begin
          MDone_i = 1'b1; MNack_i = m_nack; MRdata_ib8 = m_rdata; active = 1'b0;
        end
      end
    end
  end

  // Reference model state: round-robin pointer and last delivered read byte.
  int m_rr = 0;
  logic [7:0] m_rd = '0;

  function automatic int rr_pick(input int rr, input logic [N-1:0] req);
    for (int k = 0; k < N; k++)
      if (req[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  int lat_grant, lat_start, done_cyc;

  task automatic run_txn(input string tag, input logic [N-1:0] req, input logic [6:0] abase,
                         input logic rnw, input logic [7:0] wbase, input int delay,
                         input logic nack, input logic [7:0] mrd, input logic silent,
                         input int exp_idx, input logic exp_err, input logic [7:0] exp_rd);
    int s0, k;
    logic seen;
    m_delay = delay; m_nack = nack; m_rdata = mrd; m_silent = silent;
    for (int i = 0; i < N; i++) begin
      Addr_ib[i*7 +: 7]  = abase + 7'(i);
      Wdata_ib[i*8 +: 8] = wbase + 8'(i);
    end
    Rnw_ib = {N{rnw}};
    Req_ib = req;
    s0 = start_cnt; lat_grant = -1; lat_start = -1; seen = 1'b0; k = 0;
    while (!seen && k < 3000) begin
      @(negedge clk); k++;
      if (lat_grant < 0 && Grant_ob != '0) lat_grant = k;
      if (lat_start < 0 && MStart_o) lat_start = k;
      if (Done_ob != '0) begin
        seen = 1'b1; done_cyc = cyc;
        chk({tag, "_done"}, 32'(Done_ob), 32'(1 << exp_idx));
        chk({tag, "_grant"}, 32'(Grant_ob), 32'(1 << exp_idx));
        chk({tag, "_err"}, 32'(Err_o), 32'(exp_err));
        chk({tag, "_rdata"}, 32'(Rdata_ob8), 32'(exp_rd));
        chk({tag, "_maddr"}, 32'(MAddr_ob7), 32'(abase + 7'(exp_idx)));
        chk({tag, "_mrnw"}, 32'(MRnw_o), 32'(rnw));
        chk({tag, "_mwdata"}, 32'(MWdata_ob8), 32'(wbase + 8'(exp_idx)));
        chk({tag, "_nstarts"}, 32'(start_cnt - s0), 32'd1);
        chk({tag, "_lat_grant"}, 32'(lat_grant), 32'd2);
        chk({tag, "_lat_start"}, 32'(lat_start), 32'd3);
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    Req_ib = '0;
    m_rr = (exp_idx + 1) % N;
    m_rd = exp_rd;
    $display("[TB] txn %s req=%b idx=%0d err=%b rdata=%h", tag, req, exp_idx, Err_o, Rdata_ob8);
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] req; logic [6:0] abase; logic rnw; logic [7:0] wbase; int delay;
    logic nack; logic [7:0] mrd; int exp_idx; logic exp_err; logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[6];

  task automatic wait_cycles_for_done(output int idx);
    idx = -1;
    for (int k = 0; k < 3000 && idx < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (Done_ob[i]) idx = i;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int idx, grants, dones, k;
    int order[5];
    logic [N-1:0] req, prev_grant;
    logic rnw, nack;
    logic [7:0] mrd;

    vecs[0] = '{4'b0100, 7'h46, 1'b1, 8'h00, 100, 1'b0, 8'hA5, 2, 1'b0, 8'hA5};
    vecs[1] = '{4'b0001, 7'h50, 1'b0, 8'h3C, 10,  1'b1, 8'h77, 0, 1'b1, 8'hA5};
    vecs[2] = '{4'b1111, 7'h10, 1'b1, 8'h00, 3,   1'b0, 8'h5A, 1, 1'b0, 8'h5A};
    vecs[3] = '{4'b1001, 7'h20, 1'b0, 8'h99, 1,   1'b0, 8'h00, 3, 1'b0, 8'h5A};
    vecs[4] = '{4'b1010, 7'h30, 1'b1, 8'h00, 20,  1'b1, 8'hFF, 1, 1'b1, 8'hFF};
    vecs[5] = '{4'b0100, 7'h40, 1'b0, 8'h11, 2,   1'b0, 8'h00, 2, 1'b0, 8'hFF};

    repeat (3) @(negedge clk);
    chk("reset_outputs_a", 32'({Grant_ob, Done_ob, Rdata_ob8, Err_o, MStart_o, MAbort_o}), 32'd0);
    chk("reset_outputs_b", 32'({MAddr_ob7, MRnw_o, MWdata_ob8}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].abase, vecs[v].rnw, vecs[v].wbase,
              vecs[v].delay, vecs[v].nack, vecs[v].mrd, 1'b0,
              vecs[v].exp_idx, vecs[v].exp_err, vecs[v].exp_rd);

    // Silent master: abort 999 cycles after start, done one cycle later.
    run_txn("timeout", 4'b0010, 7'h60, 1'b1, 8'h00, 1, 1'b0, 8'hEE, 1'b1, 1, 1'b1, 8'hFF);
    chk("timeout_abort_cycle", 32'(abort_cyc - start_cyc), 32'(TMO - 1));
    chk("timeout_done_cycle", 32'(done_cyc - abort_cyc), 32'd1);
    run_txn("after_timeout", 4'b1100, 7'h08, 1'b1, 8'h00, 6, 1'b0, 8'h66, 1'b0, 2, 1'b0, 8'h66);

    // Requester drops its request after the grant; transaction still completes.
    m_delay = 30; m_nack = 1'b0; m_silent = 1'b0;
    Rnw_ib = '0; Req_ib = 4'b0010;
    k = 0;
    while (Grant_ob == '0 && k < 50) begin @(negedge clk); k++; end
    chk("drop_granted", 32'(Grant_ob), 32'b0010);
    repeat (5) @(negedge clk);
    Req_ib = '0;
    wait_cycles_for_done(idx);
    chk("drop_done_idx", 32'(idx), 32'd1);
    chk("drop_err", 32'(Err_o), 32'd0);
    $display("[TB] txn drop req=0010 idx=%0d err=%b rdata=%h", idx, Err_o, Rdata_ob8);
    m_rr = 2;
    @(negedge clk);

    for (int t = 0; t < 30; t++) begin
      req  = 4'($urandom_range(1, 15));
      rnw  = 1'($urandom);
      nack = ($urandom_range(0, 3) == 0);
      mrd  = 8'($urandom);
      idx  = rr_pick(m_rr, req);
      run_txn($sformatf("rnd%0d", t), req, 7'($urandom), rnw, 8'($urandom),
              $urandom_range(1, 25), nack, mrd, 1'b0, idx, nack, rnw ? mrd : m_rd);
    end

    // All four requesting from reset: strict rotation, one grant at a time.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_rr = 0;
    m_delay = 4; m_nack = 1'b0; m_silent = 1'b0; m_rdata = 8'hC3;
    for (int i = 0; i < N; i++) Addr_ib[i*7 +: 7] = 7'h2A;
    Rnw_ib = '1; Req_ib = '1;
    grants = 0; dones = 0; prev_grant = '0; k = 0;
    while (dones < 5 && k < 400) begin
      @(negedge clk); k++;
      if (Grant_ob != '0 && prev_grant == '0) begin
        chk("rot_grant_after_done", 32'(grants), 32'(dones));
        grants++;
      end
      prev_grant = Grant_ob;
      if (Done_ob != '0) begin
        for (int i = 0; i < N; i++) if (Done_ob[i]) order[dones] = i;
        $display("[TB] txn rot%0d req=1111 idx=%0d err=%b rdata=%h", dones, order[dones], Err_o, Rdata_ob8);
        dones++;
      end
    end
    Req_ib = '0;
    chk("rot_count", 32'(dones), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("rot_order%0d", i), 32'(order[i]), 32'(i % N));
    repeat (2) @(negedge clk);

    // Reset while waiting on the master clears outputs immediately.
    m_delay = 200;
    for (int i = 0; i < N; i++) Addr_ib[i*7 +: 7] = 7'h2A;
    Req_ib = 4'b0100;
    k = 0;
    while (!MStart_o && k < 20) begin @(negedge clk); k++; end
    chk("rst_wait_started", 32'(MStart_o), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", 32'({Grant_ob, Done_ob, Rdata_ob8, Err_o, MStart_o, MAbort_o}), 32'd0);
    chk("async_rst_b", 32'({MAddr_ob7, MRnw_o, MWdata_ob8}), 32'd0);
    Req_ib = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_rr = 0; m_rd = '0;
    @(negedge clk);
    run_txn("post_rst_rr", 4'b1001, 7'h11, 1'b0, 8'h21, 3, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00);
    run_txn("post_rst_req3", 4'b1000, 7'h12, 1'b1, 8'h00, 3, 1'b0, 8'h4D, 1'b0, 3, 1'b0, 8'h4D);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
